dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 195 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: RV32I width codes,
// FSM state encoding and default parameters.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DEPTH_WORDS = 256;

    // Sign- or zero-extend a right-aligned value of the given byte width (1 or 2).
    function automatic logic [31:0] extend(input logic [15:0] val, input logic half, input logic sgn);
        logic [31:0] res;
        if (half) begin
            res = {{16{sgn & val[15]}}, val};
        end else begin
            res = {{24{sgn & val[7]}}, val[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load lane
// extraction with extension, and width/alignment fault detection.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        fault
);

    logic [31:0] byte_sh_s;
    logic [31:0] half_sh_s;

    // Lane decode per width code; unsigned codes are load-only.
    always_comb begin
        byte_sh_s = rword >> {addr_lo, 3'b000};
        half_sh_s = rword >> {addr_lo[1], 4'b0000};
        be        = 4'b0000;
        wdata_sh  = 32'd0;
        rdata_ext = 32'd0;
        fault     = 1'b0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = extend({8'd0, byte_sh_s[7:0]}, 1'b0, 1'b1);
            end
            F3_H: begin
                fault     = addr_lo[0];
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = extend(half_sh_s[15:0], 1'b1, 1'b1);
            end
            F3_W: begin
                fault     = (addr_lo != 2'b00);
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            F3_BU: begin
                fault     = we;
                rdata_ext = extend({8'd0, byte_sh_s[7:0]}, 1'b0, 1'b0);
            end
            F3_HU: begin
                fault     = we | addr_lo[0];
                rdata_ext = extend(half_sh_s[15:0], 1'b1, 1'b0);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and
// RV32I byte/half/word load/store semantics over a word-wide backing store.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0]  S_IDLE    = ST_IDLE;
    localparam logic [1:0]  S_WAIT    = ST_WAIT;
    localparam logic [1:0]  S_RESP    = ST_RESP;
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        req_ready_q, req_ready_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        op_we_s;
    logic [2:0]  op_f3_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic [AW-1:0] mem_idx_s;
    logic [31:0] rword_s;
    logic        in_range_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_sh_s;
    logic [31:0] rdata_ext_s;
    logic        fault_s;
    logic        err_s;
    logic        enter_resp_s;
    logic        wr_en_s;

    // With LATENCY=1 the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_we_s    = req_we;
            op_f3_s    = req_funct3;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_we_s    = we_q;
            op_f3_s    = f3_q;
            op_addr_s  = addr_q;
            op_wdata_s = wdata_q;
        end
    end

    assign in_range_s = ({2'b00, op_addr_s[31:2]} < DEPTH_LIM);
    assign mem_idx_s  = op_addr_s[AW+1:2];
    assign rword_s    = mem_q[mem_idx_s];
    assign err_s      = fault_s | ~in_range_s;
    assign wr_en_s    = enter_resp_s & op_we_s & ~err_s;

    dmem_lane_align u_lane (
        .we        (op_we_s),
        .funct3    (op_f3_s),
        .addr_lo   (op_addr_s[1:0]),
        .wdata     (op_wdata_s),
        .rword     (rword_s),
        .be        (be_s),
        .wdata_sh  (wdata_sh_s),
        .rdata_ext (rdata_ext_s),
        .fault     (fault_s)
    );

    // Next-state and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY <= 1) begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d      = S_RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (enter_resp_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_s;
            rsp_rdata_d = (err_s || op_we_s) ? 32'd0 : rdata_ext_s;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end
        req_ready_d = (state_d == S_IDLE);
    end

    // Control and response registers; req_ready stays low while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Backing store is never reset; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && be_s[i]) begin
                mem_q[mem_idx_s][i*8 +: 8] <= wdata_sh_s[i*8 +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a LATENCY=2 responder for the main load/store, error,
// backpressure and reset-abort sequences, and a LATENCY=1 responder for back-to-back traffic.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1 = 1'b0, req_we1 = 1'b0;
    logic        rsp_ready1 = 1'b1;
    logic [2:0]  req_funct31 = 3'd0;
    logic [31:0] req_addr1 = 32'd0, req_wdata1 = 32'd0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    logic [32:0] sb2[$];
    logic [32:0] sb1[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_funct3(req_funct31), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard for the LATENCY=2 responder: compare on every response handshake.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset && rsp_valid && rsp_ready) begin
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                check_val("l2_rdata", rsp_rdata, e[31:0]);
                check_val("l2_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end else begin
                check_val("l2_sb_underflow", 32'(sb2.size()), 32'd1);
            end
        end
    end

    // Scoreboard for the LATENCY=1 responder.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset && rsp_valid1 && rsp_ready1) begin
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check_val("l1_rdata", rsp_rdata1, e[31:0]);
                check_val("l1_err", {31'd0, rsp_err1}, {31'd0, e[32]});
            end else begin
                check_val("l1_sb_underflow", 32'(sb1.size()), 32'd1);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        if (push) sb2.push_back({ee, er});
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = f3 ^ 3'd7;
        req_addr   = ~addr;
        req_wdata  = ~wd;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int lat;
        issue(we, f3, addr, wd, er, ee, 1'b1);
        wait_rsp(lat);
        check_val("latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
    endtask

    logic        t_we  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  t_f3  [4] = '{3'd2, 3'd2, 3'd0, 3'd5};
    logic [31:0] t_ad  [4] = '{32'h8, 32'h8, 32'h9, 32'h8};
    logic [31:0] t_wd  [4] = '{32'hCAFEF00D, 32'h0, 32'h11, 32'h0};
    logic [31:0] t_ex  [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0000110D};

    initial begin
        int lat;
        int n;
        int prev;
        // Reset state
        @(negedge clk);
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rdata", rsp_rdata, 32'd0);
        check_val("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Basic store/load and lane handling
        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact(1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact(1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        xact(1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        xact(1'b0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        xact(1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        xact(1'b1, 3'd0, 32'h11, 32'h55, 32'h0, 1'b0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Faults leave memory untouched
        xact(1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1);
        xact(1'b1, 3'd1, 32'h11, 32'hFFFF, 32'h0, 1'b1);
        xact(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
        xact(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        xact(1'b1, 3'd4, 32'h10, 32'h77, 32'h0, 1'b1);
        xact(1'b1, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Backpressure: response held stable while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        wait_rsp(lat);
        check_val("bp_latency", 32'(lat), 32'd2);
        repeat (5) begin
            check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("bp_rdata", rsp_rdata, 32'hDEAD55EF);
            check_val("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_rel_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset during WAIT aborts an uncommitted store
        xact(1'b1, 3'd2, 32'h20, 32'hAAAA5555, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("abort_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("abort_rdata", rsp_rdata, 32'd0);
        check_val("abort_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 3'd2, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);
        xact(1'b1, 3'd1, 32'h22, 32'h1234, 32'h0, 1'b0);
        xact(1'b0, 3'd2, 32'h20, 32'h0, 32'h12345555, 1'b0);

        // LATENCY=1: back-to-back requests with rsp_ready tied high
        @(negedge clk);
        req_valid1  = 1'b1;
        req_we1     = t_we[0];
        req_funct31 = t_f3[0];
        req_addr1   = t_ad[0];
        req_wdata1  = t_wd[0];
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!req_ready1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check_val("l1_ready", {31'd0, req_ready1}, 32'd1);
            if (k > 0) check_val("l1_spacing", 32'(cyc - prev), 32'd2);
            prev = cyc;
            @(posedge clk);
            sb1.push_back({1'b0, t_ex[k]});
            #1;
            if (k < 3) begin
                req_we1     = t_we[k+1];
                req_funct31 = t_f3[k+1];
                req_addr1   = t_ad[k+1];
                req_wdata1  = t_wd[k+1];
            end else begin
                req_valid1 = 1'b0;
                req_addr1  = 32'hFFFFFFFF;
            end
            @(negedge clk);
            check_val("l1_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
            check_val("l1_ready_low", {31'd0, req_ready1}, 32'd0);
        end

        repeat (3) @(negedge clk);
        check_val("l2_sb_drained", 32'(sb2.size()), 32'd0);
        check_val("l1_sb_drained", 32'(sb1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
